// File: rtl/alu_op_sequencer_if.sv
// Request-side valid/ready bundle for alu_op_sequencer.
// The master drives complete ALU operations; the slave (sequencer) returns req_ready.
interface alu_op_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_opa;
   logic [DATA_WIDTH-1:0] req_opb;
   logic [CMD_WIDTH-1:0]  req_cmd;
   logic                  req_mode;
   logic                  req_cin;
   logic [1:0]            req_split;
   logic [4:0]            req_gap;

   modport master (
      output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_split, req_gap,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_split, req_gap,
      output req_ready
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the ALU: FIFO-buffers operations, replays them paired or split,
// and strobes when the ALU outputs belong to the operation. Optional: ALU_SEQ_GAP_CLAMP_EN.
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int RESULT_LAT = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   alu_op_sequencer_if.slave     req,
   output logic [1:0]            INP_VALID,
   output logic [DATA_WIDTH-1:0] OPA,
   output logic [DATA_WIDTH-1:0] OPB,
   output logic [CMD_WIDTH-1:0]  CMD,
   output logic                  MODE,
   output logic                  CIN,
   output logic                  CE,
   output logic                  res_strobe,
   output logic                  busy,
   output logic                  gap_warn
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LAT_W = $clog2(RESULT_LAT + 2);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] opa;
      logic [DATA_WIDTH-1:0] opb;
      logic [CMD_WIDTH-1:0]  cmd;
      logic                  mode;
      logic                  cin;
      logic [1:0]            split;
      logic [4:0]            gap;
   } req_t;

   typedef enum logic [2:0] {
      IDLE, ISSUE_P, ISSUE_1, GAP, ISSUE_2, WAIT
   } state_t;

   req_t             mem [FIFO_DEPTH];
   req_t             wr_data;
   req_t             head;
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   state_t           state_reg;
   logic [1:0]       split_reg;
   logic [4:0]       gap_cnt_reg;
   logic [LAT_W-1:0] wait_cnt_reg;
   logic [LAT_W-1:0] lat;
   logic             extra_stage;
   logic [4:0]       pop_gap;
   logic             warn_set;
   logic             active_next;

   assign wr_data = {req.req_opa, req.req_opb, req.req_cmd, req.req_mode,
                     req.req_cin, req.req_split, req.req_gap};
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign push       = req.req_valid && !full;
   assign pop        = (state_reg == IDLE) && !empty;
   assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

   assign req.req_ready = !full;
   assign CE            = RST | (state_reg != IDLE);

`ifdef ALU_SEQ_GAP_CLAMP_EN
   assign pop_gap  = head.gap[4] ? 5'd15 : head.gap;
   assign warn_set = 1'b0;
`else
   assign pop_gap  = head.gap;
   assign warn_set = head.gap[4];
`endif

   // Multiply and shift-subtract carry one extra ALU register stage.
   assign extra_stage = MODE && ((CMD == CMD_WIDTH'(9)) || (CMD == CMD_WIDTH'(10)));
   assign lat         = LAT_W'(RESULT_LAT) + LAT_W'(extra_stage);

   always_comb begin
      active_next = 1'b1;
      if (state_reg == IDLE)
         active_next = !empty;
      else if ((state_reg == WAIT) && (wait_cnt_reg == '0))
         active_next = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Outputs are registered from the current state, so each transfer appears one cycle
   // after its issue state and is captured by the ALU at the end of that cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         INP_VALID    <= 2'b00;
         OPA          <= '0;
         OPB          <= '0;
         CMD          <= '0;
         MODE         <= 1'b0;
         CIN          <= 1'b0;
         res_strobe   <= 1'b0;
         busy         <= 1'b0;
         gap_warn     <= 1'b0;
         split_reg    <= 2'b00;
         gap_cnt_reg  <= '0;
         wait_cnt_reg <= '0;
      end else begin
         INP_VALID  <= 2'b00;
         res_strobe <= 1'b0;
         busy       <= active_next || (count_next != '0);
         case (state_reg)
            IDLE: begin
               if (!empty) begin
                  OPA         <= head.opa;
                  OPB         <= head.opb;
                  CMD         <= head.cmd;
                  MODE        <= head.mode;
                  CIN         <= head.cin;
                  split_reg   <= head.split;
                  gap_cnt_reg <= pop_gap;
                  if (warn_set)
                     gap_warn <= 1'b1;
                  if ((head.split == 2'b01) || (head.split == 2'b10))
                     state_reg <= ISSUE_1;
                  else
                     state_reg <= ISSUE_P;
               end
            end
            ISSUE_P: begin
               INP_VALID    <= 2'b11;
               wait_cnt_reg <= lat;
               state_reg    <= WAIT;
            end
            ISSUE_1: begin
               INP_VALID <= split_reg;
               state_reg <= (gap_cnt_reg != '0) ? GAP : ISSUE_2;
            end
            GAP: begin
               gap_cnt_reg <= gap_cnt_reg - 1'b1;
               if (gap_cnt_reg <= 5'd1)
                  state_reg <= ISSUE_2;
            end
            ISSUE_2: begin
               INP_VALID    <= ~split_reg;
               wait_cnt_reg <= lat;
               state_reg    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_reg == '0) begin
                  res_strobe <= 1'b1;
                  state_reg  <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected transfers/strobes queued at push,
// checked by an independent monitor on the falling edge.
module tb_alu_op_sequencer;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] INP_VALID;
   logic [7:0] OPA, OPB;
   logic [3:0] CMD;
   logic       MODE, CIN, CE, res_strobe, busy, gap_warn;

   alu_op_sequencer_if #(.DATA_WIDTH(8), .CMD_WIDTH(4)) bus ();

   alu_op_sequencer #(.DATA_WIDTH(8), .CMD_WIDTH(4), .FIFO_DEPTH(4), .RESULT_LAT(1)) dut (
      .CLK(CLK), .RST(RST), .req(bus),
      .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
      .CE(CE), .res_strobe(res_strobe), .busy(busy), .gap_warn(gap_warn)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      bit         strobe;
      logic [1:0] iv;
      logic [21:0] f;
      int         delta;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   bit          mid_op = 0;
   logic [21:0] cur_f;
   exp_t        mon_e;
   int          mon_dt;
   int          waited;

`ifdef ALU_SEQ_GAP_CLAMP_EN
   localparam logic EXP_WARN = 1'b0;
`else
   localparam logic EXP_WARN = 1'b1;
`endif

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (RST) begin
         mid_op = 0;
      end else begin
         if (mid_op) begin
            total++;
            if ({OPA, OPB, CMD, MODE, CIN} !== cur_f) begin
               bad++;
               $display("FAIL hold: fields got %h want %h", {OPA, OPB, CMD, MODE, CIN}, cur_f);
            end
         end
         if ((INP_VALID != 2'b00) || res_strobe) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected: iv=%b strobe=%b", INP_VALID, res_strobe);
            end else begin
               mon_e  = sb.pop_front();
               mon_dt = cyc - last_cyc;
               if ((res_strobe !== mon_e.strobe) ||
                   (!mon_e.strobe && ((INP_VALID !== mon_e.iv) || ({OPA, OPB, CMD, MODE, CIN} !== mon_e.f))) ||
                   ((mon_e.delta != 0) && (mon_dt != mon_e.delta))) begin
                  bad++;
                  $display("FAIL %s: got strobe=%b iv=%b f=%h dt=%0d want strobe=%b iv=%b f=%h dt=%0d",
                           mon_e.name, res_strobe, INP_VALID, {OPA, OPB, CMD, MODE, CIN}, mon_dt,
                           mon_e.strobe, mon_e.iv, mon_e.f, mon_e.delta);
               end else begin
                  $display("ok %s: strobe=%b iv=%b f=%h dt=%0d", mon_e.name, res_strobe,
                           INP_VALID, {OPA, OPB, CMD, MODE, CIN}, mon_dt);
               end
            end
            last_cyc = cyc;
            if (res_strobe) begin
               mid_op = 0;
            end else begin
               mid_op = 1;
               cur_f  = {OPA, OPB, CMD, MODE, CIN};
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end else begin
         $display("ok %s: %0h", nm, got);
      end
   endtask

   // lat is the hand-computed ALU latency for the vector.
   task automatic expect_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] c, input logic m, input logic ci,
                            input logic [1:0] sp, input int g, input int lat);
      exp_t e;
      int   eg;
      eg = g;
`ifdef ALU_SEQ_GAP_CLAMP_EN
      if (eg > 15) eg = 15;
`endif
      e.name = nm;
      e.f = {a, b, c, m, ci};
      e.strobe = 0;
      if ((sp == 2'b01) || (sp == 2'b10)) begin
         e.iv = sp;  e.delta = 0;      sb.push_back(e);
         e.iv = ~sp; e.delta = eg + 1; sb.push_back(e);
      end else begin
         e.iv = 2'b11; e.delta = 0; sb.push_back(e);
      end
      e.strobe = 1;
      e.iv = 2'b00;
      e.delta = lat + 1;
      sb.push_back(e);
   endtask

   task automatic push_req(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m, input logic ci,
                           input logic [1:0] sp, input logic [4:0] g, input int lat,
                           output int w);
      logic rdy;
      bit   ok;
      bus.req_valid = 1'b1;
      bus.req_opa = a; bus.req_opb = b; bus.req_cmd = c; bus.req_mode = m;
      bus.req_cin = ci; bus.req_split = sp; bus.req_gap = g;
      w = 0;
      ok = 0;
      while (1) begin
         rdy = bus.req_ready;
         @(posedge CLK);
         #1;
         if (rdy) begin
            ok = 1;
            break;
         end
         w++;
         if (w > 300) begin
            total++;
            bad++;
            $display("FAIL push_timeout %s: got no ready want ready", nm);
            break;
         end
      end
      bus.req_valid = 1'b0;
      if (ok) begin
         expect_op(nm, a, b, c, m, ci, sp, int'(g), lat);
         $display("push %s: opa=%h opb=%h cmd=%0d mode=%b split=%b gap=%0d waited=%0d",
                  nm, a, b, c, m, sp, g, w);
      end
   endtask

   task automatic wait_done(input string nm);
      int t;
      t = 0;
      while ((sb.size() != 0) && (t < 500)) begin
         @(posedge CLK);
         #1;
         t++;
      end
      chk({nm, "_drained"}, sb.size(), 0);
      @(posedge CLK);
      #1;
      chk({nm, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 0; bus.req_opa = 0; bus.req_opb = 0; bus.req_cmd = 0;
      bus.req_mode = 0; bus.req_cin = 0; bus.req_split = 0; bus.req_gap = 0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ce", {31'd0, CE}, 1);
      chk("rst_iv", {30'd0, INP_VALID}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ready", {31'd0, bus.req_ready}, 1);
      RST = 1'b0;
      #1;
      chk("idle_ce", {31'd0, CE}, 0);

      push_req("add", 8'h0A, 8'h05, 4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 1, waited);
      wait_done("add");
      chk("warn_after_add", {31'd0, gap_warn}, 0);

      push_req("split01", 8'h33, 8'h11, 4'd1, 1'b1, 1'b1, 2'b01, 5'd3, 1, waited);
      wait_done("split01");

      push_req("mul", 8'h07, 8'h06, 4'd9, 1'b1, 1'b0, 2'b10, 5'd0, 2, waited);
      wait_done("mul");

      push_req("split11_logic9", 8'hF0, 8'h3C, 4'd9, 1'b0, 1'b0, 2'b11, 5'd7, 1, waited);
      wait_done("split11");

      // Reset in the middle of a gap drops both the in-flight and the queued request.
      push_req("rstA", 8'h5A, 8'hA5, 4'd2, 1'b0, 1'b0, 2'b01, 5'd10, 1, waited);
      push_req("rstB", 8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 1, waited);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      sb.delete();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("midrst_iv", {30'd0, INP_VALID}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_ready", {31'd0, bus.req_ready}, 1);
      chk("midrst_strobe", {31'd0, res_strobe}, 0);
      chk("midrst_opa", {24'd0, OPA}, 0);
      chk("midrst_cmd", {28'd0, CMD}, 0);
      repeat (30) @(posedge CLK);
      #1;
      chk("midrst_still_idle", {31'd0, busy}, 0);

      // FIFO full while the first request sits in a long gap.
      push_req("full1", 8'h81, 8'h01, 4'd2, 1'b1, 1'b0, 2'b01, 5'd20, 1, waited);
      repeat (4) @(posedge CLK);
      #1;
      push_req("full2", 8'h82, 8'h02, 4'd0, 1'b1, 1'b0, 2'b00, 5'd0, 1, waited);
      push_req("full3", 8'h83, 8'h03, 4'd1, 1'b0, 1'b1, 2'b00, 5'd0, 1, waited);
      push_req("full4", 8'h84, 8'h04, 4'd10, 1'b1, 1'b0, 2'b00, 5'd0, 2, waited);
      push_req("full5", 8'h85, 8'h05, 4'd3, 1'b1, 1'b0, 2'b00, 5'd0, 1, waited);
      chk("full_ready_low", {31'd0, bus.req_ready}, 0);
      chk("full_gap_warn", {31'd0, gap_warn}, {31'd0, EXP_WARN});
      push_req("full6", 8'h86, 8'h06, 4'd0, 1'b1, 1'b0, 2'b10, 5'd1, 1, waited);
      chk("full6_waited_for_pop", (waited >= 5) ? 32'd1 : 32'd0, 1);
      wait_done("full");
      chk("final_gap_warn", {31'd0, gap_warn}, {31'd0, EXP_WARN});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
